// File: rtl/corr_tap_line.sv
// Correlator tap line: last TAPS accepted samples (decimated by DECIM), fill/window status, optional running sum.
// Latency 1 from accept to taps/status; no backpressure. Optional running sum is built only when TAPLINE_RUNSUM_EN is defined.
module corr_tap_line #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 20,
  parameter int DECIM  = 1,
  parameter int FILL_W = $clog2(TAPS + 1),
  parameter int SUM_W  = DATA_W + $clog2(TAPS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ena_i,
  input  logic [DATA_W-1:0]        rec_i,
  input  logic                     flush_i,
  output logic [TAPS*DATA_W-1:0]   taps_o,
  output logic [FILL_W-1:0]        fill_o,
  output logic                     win_valid_o,
  output logic                     win_stb_o,
  output logic [SUM_W-1:0]         tap_sum_o
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

  logic [DATA_W-1:0] tap_q [TAPS];
  logic [DATA_W-1:0] tap_d [TAPS];
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              win_valid_q, win_valid_d;
  logic              win_stb_q, win_stb_d;
  logic              accept;

  assign accept = ena_i && (dcnt_q == '0);

  always_comb begin
    dcnt_d = dcnt_q;
    if (ena_i) begin
      dcnt_d = (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + DCNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      tap_d[i] = tap_q[i];
    end
    if (accept) begin
      tap_d[0] = rec_i;
      for (int i = 1; i < TAPS; i++) begin
        tap_d[i] = tap_q[i-1];
      end
    end
  end

  // Strobe marks every accept that leaves the line full, including the one that first fills it.
  always_comb begin
    fill_d = fill_q;
    if (accept && (fill_q != FILL_FULL)) begin
      fill_d = fill_q + FILL_W'(1);
    end
    win_valid_d = (fill_d == FILL_FULL);
    win_stb_d   = accept && (fill_d == FILL_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i] <= '0;
      end
      dcnt_q      <= '0;
      fill_q      <= '0;
      win_valid_q <= 1'b0;
      win_stb_q   <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i] <= tap_d[i];
      end
      dcnt_q      <= dcnt_d;
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
      win_stb_q   <= win_stb_d;
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_taps
    assign taps_o[g*DATA_W +: DATA_W] = tap_q[g];
  end

  assign fill_o      = fill_q;
  assign win_valid_o = win_valid_q;
  assign win_stb_o   = win_stb_q;

`ifdef TAPLINE_RUNSUM_EN
  // Empty taps hold zero, so subtracting the outgoing tap is exact even while filling.
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] rec_ext, old_ext;

  assign rec_ext = {{(SUM_W-DATA_W){rec_i[DATA_W-1]}}, rec_i};
  assign old_ext = {{(SUM_W-DATA_W){tap_q[TAPS-1][DATA_W-1]}}, tap_q[TAPS-1]};

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = sum_q + rec_ext - old_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign tap_sum_o = sum_q;
`else
  assign tap_sum_o = '0;
`endif

endmodule

// File: doc/corr_tap_line.md
Name: corr_tap_line

Overview:
- Parametrised successor of the correlator sample shift register.
- Holds the last TAPS signed samples of the received stream as a flattened tap bus, and feeds the correlator multiply-accumulate array.
- Adds input decimation, a fill counter with window-valid and per-window strobe, synchronous flush, and an optional running sum of the taps for mean removal.

Parameters:
- DATA_W, 8, sample width in bits (signed, two's complement)
- TAPS, 20, number of delay taps (>=2)
- DECIM, 1, accept one of every DECIM enabled samples (>=1)
- FILL_W, $clog2(TAPS+1), fill counter width (derived, not overridden)
- SUM_W, DATA_W+$clog2(TAPS), running sum width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  input sample qualifier; rec is sampled only when ena=1
- rec  in  DATA_W  signed input sample
- flush  in  1  synchronous clear of taps, fill and decimation state
- taps  out  TAPS*DATA_W  flattened taps; bits [(i+1)*DATA_W-1 : i*DATA_W] = tap i; tap 0 is newest
- fill  out  FILL_W  number of valid taps, saturating at TAPS
- win_valid  out  1  high while fill==TAPS
- win_stb  out  1  one-cycle pulse when a new full window is presented
- tap_sum  out  SUM_W  signed sum of all taps (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge) forces all taps=0, fill=0, win_valid=0, win_stb=0, tap_sum=0, and the decimation counter to 0. Reset has priority over everything.
- Decimation counter dcnt, range 0..DECIM-1:
  - Advances on each ena=1 cycle and wraps to 0 after DECIM-1.
  - A sample is accepted when ena=1 and dcnt==0.
  - With DECIM=1, every ena=1 cycle accepts.
- Accept at edge k:
  - tap i <= tap i-1 for i=1..TAPS-1; tap 0 <= rec; old tap TAPS-1 is discarded.
  - New taps are visible from cycle k+1 (latency 1).
- fill increments by 1 on each accept and saturates at TAPS. win_valid = (fill==TAPS), registered alongside fill.
- win_stb is 1 in the cycle after an accept whose updated fill equals TAPS. It is therefore coincident with the new tap values.
  - It pulses once per accepted sample after the line is full.
  - On the accept that first fills the line, win_stb and win_valid rise together.
- ena=0 holds all state; win_stb=0.
- flush=1 at an edge (rst=0) produces the same result as reset for taps, fill, win_valid, win_stb, dcnt and tap_sum.
  - flush and ena in the same cycle: flush wins and the sample is dropped.
- No backpressure: the block always accepts, and the consumer must sample taps on win_stb.
- Arithmetic: taps are stored raw, with no saturation or rounding.

Optional Feature:
- Macro TAPLINE_RUNSUM_EN.
- Defined:
  - On each accept, tap_sum <= tap_sum + sext(rec) - sext(tap TAPS-1), all in SUM_W signed arithmetic.
  - Taps beyond fill are zero, so the sum is exact during fill.
  - Reset and flush clear tap_sum. Latency 1, coincident with taps.
- Not defined: tap_sum is tied to 0 and no adder logic is built.

Test Plan:
- Reset then feed rec=1,2,...,20 with ena=1 every cycle, DECIM=1:
  - fill counts 1..20; win_valid and win_stb rise the cycle after the 20th sample.
  - tap0=20, tap19=1.
  - With RUNSUM, tap_sum=210.
- Continue with rec=21: tap0=21, tap19=2, win_stb pulses again; with RUNSUM, tap_sum=230. Then ena=0 for 5 cycles: taps hold, win_stb=0.
- Signed check, TAPS=4: feed -128,127,-1,0.
  - Taps are 0x00,0xFF,0x7F,0x80 from tap0 to tap3.
  - With RUNSUM, tap_sum=-2 (SUM_W=10 gives 0x3FE).
- DECIM=3, TAPS=4: ena=1 continuously with rec=0..11. Only 0,3,6,9 are accepted; tap0=9, tap3=0; win_stb fires once, after the rec=9 cycle.
- Mid-fill (fill=7): assert flush together with ena and rec=55. Next cycle fill=0, all taps=0, win_valid=0, 55 not stored; the next accept gives fill=1.
- With the line full, assert rst for 1 cycle alongside ena=1: every output returns to its reset value and no win_stb pulse occurs.
